// File: rtl/cam_param_sync_pkg.sv
// Shared types and defaults for the camera parameter synchroniser.
package cam_param_sync_pkg;

    localparam int unsigned CAM_DATA_W_DEF     = 32;
    localparam int unsigned CAM_FRAME_ID_W_DEF = 8;
    localparam int unsigned DROP_CNT_W         = 16;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } cam_state_e;

    typedef struct packed {
        logic [CAM_DATA_W_DEF-1:0] x;
        logic [CAM_DATA_W_DEF-1:0] y;
        logic [CAM_DATA_W_DEF-1:0] z;
    } cam_params_t;

endpackage

// File: rtl/cam_sync_drop_cnt.sv
// Saturating counter of frame_start pulses dropped while a snapshot is stalled.
module cam_sync_drop_cnt
    import cam_param_sync_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  inc_i,
    output logic [DROP_CNT_W-1:0] cnt_o
);

    logic [DROP_CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + DROP_CNT_W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/cam_param_sync.sv
// Frame-coherent camera eye snapshot with valid/ready presentation.
// Optional drop statistics under CAM_PARAM_SYNC_STATS_EN.
module cam_param_sync
    import cam_param_sync_pkg::*;
#(
    parameter int unsigned DATA_W     = CAM_DATA_W_DEF,
    parameter int unsigned FRAME_ID_W = CAM_FRAME_ID_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_W-1:0]     eye_x_in,
    input  logic [DATA_W-1:0]     eye_y_in,
    input  logic [DATA_W-1:0]     eye_z_in,
    input  logic                  frame_start,
    output logic                  cam_valid,
    input  logic                  cam_ready,
    output logic [DATA_W-1:0]     cam_eye_x,
    output logic [DATA_W-1:0]     cam_eye_y,
    output logic [DATA_W-1:0]     cam_eye_z,
    output logic [FRAME_ID_W-1:0] cam_frame_id,
    output logic                  cam_changed,
    output logic                  busy
`ifdef CAM_PARAM_SYNC_STATS_EN
   ,output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

    localparam int unsigned SNAP_W = 3 * DATA_W;

    cam_state_e            state_q, state_d;
    logic [SNAP_W-1:0]     in_q;
    logic [SNAP_W-1:0]     snap_q, snap_d;
    logic [SNAP_W-1:0]     base_q, base_d;
    logic [FRAME_ID_W-1:0] fid_q, fid_d;
    logic                  chg_q, chg_d;
    logic                  take;

    // Input stage: free-running, one cycle behind the PIO words.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_q <= '0;
        end else begin
            in_q <= {eye_x_in, eye_y_in, eye_z_in};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            snap_q  <= '0;
            base_q  <= '0;
            fid_q   <= '0;
            chg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            base_q  <= base_d;
            fid_q   <= fid_d;
            chg_q   <= chg_d;
        end
    end

    // base_d already holds the snapshot being accepted this cycle, so it is
    // the correct reference for a back-to-back change comparison.
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        base_d  = base_q;
        fid_d   = fid_q;
        chg_d   = chg_q;
        take    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    take    = 1'b1;
                    state_d = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (cam_ready) begin
                    base_d = snap_q;
                    if (frame_start) begin
                        take = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (take) begin
            snap_d = in_q;
            fid_d  = fid_q + FRAME_ID_W'(1);
            chg_d  = (in_q != base_d);
        end
    end

    assign cam_valid    = (state_q == ST_PRESENT);
    assign busy         = (state_q == ST_PRESENT);
    assign cam_eye_x    = snap_q[2*DATA_W +: DATA_W];
    assign cam_eye_y    = snap_q[DATA_W   +: DATA_W];
    assign cam_eye_z    = snap_q[0        +: DATA_W];
    assign cam_frame_id = fid_q;
    assign cam_changed  = chg_q;

`ifdef CAM_PARAM_SYNC_STATS_EN
    logic drop_c;

    assign drop_c = (state_q == ST_PRESENT) && frame_start && !cam_ready;

    cam_sync_drop_cnt u_drop_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc_i   (drop_c),
        .cnt_o   (drop_cnt)
    );
`endif

endmodule

// File: tb/tb_cam_param_sync.sv
// Bench for cam_param_sync: two instances (8-bit and 2-bit frame id) against a
// behavioural model, plus directed literal checks.
module tb_cam_param_sync;
    import cam_param_sync_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] eye_x = '0, eye_y = '0, eye_z = '0;
    logic        frame_start = 1'b0;
    logic        cam_ready = 1'b0;

    logic        v8, b8, c8, v2, b2, c2;
    logic [31:0] x8, y8, z8, x2, y2, z2;
    logic [7:0]  id8;
    logic [1:0]  id2;
`ifdef CAM_PARAM_SYNC_STATS_EN
    logic [15:0] dc8, dc2;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cam_param_sync #(.DATA_W(32), .FRAME_ID_W(8)) dut8 (
        .clk(clk), .reset_n(reset_n),
        .eye_x_in(eye_x), .eye_y_in(eye_y), .eye_z_in(eye_z),
        .frame_start(frame_start), .cam_valid(v8), .cam_ready(cam_ready),
        .cam_eye_x(x8), .cam_eye_y(y8), .cam_eye_z(z8),
        .cam_frame_id(id8), .cam_changed(c8), .busy(b8)
`ifdef CAM_PARAM_SYNC_STATS_EN
       ,.drop_cnt(dc8)
`endif
    );

    cam_param_sync #(.DATA_W(32), .FRAME_ID_W(2)) dut2 (
        .clk(clk), .reset_n(reset_n),
        .eye_x_in(eye_x), .eye_y_in(eye_y), .eye_z_in(eye_z),
        .frame_start(frame_start), .cam_valid(v2), .cam_ready(cam_ready),
        .cam_eye_x(x2), .cam_eye_y(y2), .cam_eye_z(z2),
        .cam_frame_id(id2), .cam_changed(c2), .busy(b2)
`ifdef CAM_PARAM_SYNC_STATS_EN
       ,.drop_cnt(dc2)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: presentation rules expressed on whole snapshots.
    cam_params_t m_snap = '0, m_last_acc = '0, m_prev_in = '0;
    bit          m_valid = 0;
    bit          m_chg = 0;
    int          m_id = 0;
    int          m_drops = 0;

    always @(posedge clk or negedge reset_n) begin
        bit accepted;
        if (!reset_n) begin
            m_valid = 0; m_snap = '0; m_last_acc = '0; m_prev_in = '0;
            m_id = 0; m_chg = 0; m_drops = 0;
        end else begin
            accepted = m_valid && cam_ready;
            if (accepted) m_last_acc = m_snap;
            if (frame_start && (!m_valid || accepted)) begin
                m_snap  = m_prev_in;
                m_id    = m_id + 1;
                m_chg   = (m_snap != m_last_acc);
                m_valid = 1;
            end else if (accepted) begin
                m_valid = 0;
            end else if (frame_start) begin
                if (m_drops < 65535) m_drops = m_drops + 1;
            end
            m_prev_in = '{x: eye_x, y: eye_y, z: eye_z};
        end
    end

    // Compare process: every falling edge, away from the active edge.
    always @(negedge clk) begin
        chk("valid8", 64'(v8), 64'(m_valid));
        chk("busy8",  64'(b8), 64'(m_valid));
        chk("valid2", 64'(v2), 64'(m_valid));
        chk("busy2",  64'(b2), 64'(m_valid));
        if (m_valid) begin
            chk("eye_x8", 64'(x8), 64'(m_snap.x));
            chk("eye_y8", 64'(y8), 64'(m_snap.y));
            chk("eye_z8", 64'(z8), 64'(m_snap.z));
            chk("eye_x2", 64'(x2), 64'(m_snap.x));
            chk("id8",    64'(id8), 64'(m_id % 256));
            chk("id2",    64'(id2), 64'(m_id % 4));
            chk("chg8",   64'(c8), 64'(m_chg));
            chk("chg2",   64'(c2), 64'(m_chg));
        end
`ifdef CAM_PARAM_SYNC_STATS_EN
        chk("drop8", 64'(dc8), 64'(m_drops));
`endif
    end

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    initial begin
        logic [1:0] wrap_exp [5];
        wrap_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        step(3);
        chk("rst_valid", 64'(v8), 64'd0);
        chk("rst_busy",  64'(b8), 64'd0);
        chk("rst_eye",   64'({x8, y8} | 64'(z8)), 64'd0);
        chk("rst_id",    64'(id8), 64'd0);
        chk("rst_chg",   64'(c8), 64'd0);
        reset_n = 1'b1;

        // Basic snapshot; cam_ready in IDLE first has no effect.
        eye_x = 32'h0001_0000; eye_y = 32'h0002_0000; eye_z = 32'hFFFF_0000;
        cam_ready = 1'b1;
        step(3);
        chk("idle_ready", 64'(v8), 64'd0);
        cam_ready = 1'b0;
        step(2);
        pulse_fs();
        chk("basic_valid", 64'(v8), 64'd1);
        chk("basic_x", 64'(x8), 64'h0001_0000);
        chk("basic_z", 64'(z8), 64'hFFFF_0000);
        chk("basic_id", 64'(id8), 64'd1);
        chk("basic_chg", 64'(c8), 64'd1);

        // Stall while eye_x changes.
        eye_x = 32'h7;
        step(5);
        chk("stall_x", 64'(x8), 64'h0001_0000);
        chk("stall_valid", 64'(v8), 64'd1);
        cam_ready = 1'b1;
        step();
        cam_ready = 1'b0;
        chk("stall_done", 64'(v8), 64'd0);

        // Back-to-back with unchanged inputs.
        step(2);
        pulse_fs();
        chk("b2b_first_x", 64'(x8), 64'h7);
        chk("b2b_first_id", 64'(id8), 64'd2);
        step(2);
        cam_ready = 1'b1; frame_start = 1'b1;
        step();
        cam_ready = 1'b0; frame_start = 1'b0;
        chk("b2b_valid", 64'(v8), 64'd1);
        chk("b2b_id", 64'(id8), 64'd3);
        chk("b2b_chg", 64'(c8), 64'd0);

        // Three drops during a stall.
        eye_y = 32'h1234;
        for (int i = 0; i < 3; i++) begin
            pulse_fs();
            step();
        end
        chk("drop_y", 64'(y8), 64'h0002_0000);
        chk("drop_id", 64'(id8), 64'd3);
`ifdef CAM_PARAM_SYNC_STATS_EN
        chk("drop_cnt", 64'(dc8), 64'd3);
`endif
        cam_ready = 1'b1;
        step();
        cam_ready = 1'b0;

        // Five further accepted frames: 2-bit id runs 0,1,2,3,0.
        for (int k = 0; k < 5; k++) begin
            eye_z = 32'(k);
            step(2);
            pulse_fs();
            chk("wrap_id2", 64'(id2), 64'(wrap_exp[k]));
            cam_ready = 1'b1;
            step();
            cam_ready = 1'b0;
        end
        chk("wrap_id8", 64'(id8), 64'd8);

        // Reset mid-PRESENT, then frame against a zero baseline.
        pulse_fs();
        reset_n = 1'b0;
        #1;
        chk("rstp_valid", 64'(v8), 64'd0);
        chk("rstp_id", 64'(id8), 64'd0);
        chk("rstp_eye", 64'(x8), 64'd0);
        step(2);
        reset_n = 1'b1;
        eye_x = '0; eye_y = '0; eye_z = '0;
        step(2);
        pulse_fs();
        chk("post_rst_id", 64'(id8), 64'd1);
        chk("post_rst_chg0", 64'(c8), 64'd0);
        cam_ready = 1'b1;
        step();
        cam_ready = 1'b0;
        eye_y = 32'h55;
        step(2);
        pulse_fs();
        chk("post_rst_id2", 64'(id8), 64'd2);
        chk("post_rst_chg1", 64'(c8), 64'd1);

        // Mixed traffic, checked by the model on every cycle.
        for (int i = 0; i < 300; i++) begin
            eye_x       = 32'($urandom_range(0, 3));
            eye_y       = 32'($urandom_range(0, 1));
            frame_start = 1'($urandom_range(0, 2) == 0);
            cam_ready   = 1'($urandom_range(0, 1));
            step();
        end
        frame_start = 1'b0;
        cam_ready   = 1'b0;
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
